// File: rtl/beta_host_pkg.sv
// Shared definitions for the Beta host-side mau initiator: command op codes,
// response status codes, controller state encoding and read-latency bounds.
package beta_host_pkg;

    typedef enum logic [2:0] {
        OP_WR_IM   = 3'd0,
        OP_WR_DM   = 3'd1,
        OP_WR_RF   = 3'd2,
        OP_RD_IM   = 3'd3,
        OP_RD_DM   = 3'd4,
        OP_RD_RF   = 3'd5,
        OP_RUN     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_HALTED  = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ILLEGAL = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_RD_WAIT,
        S_RSP,
        S_RUN
    } state_e;

    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 4;

    function automatic logic is_write(input op_e op);
        return (op == OP_WR_IM) || (op == OP_WR_DM) || (op == OP_WR_RF);
    endfunction

endpackage

// File: rtl/beta_run_timer.sv
// Saturating run-cycle counter with budget compare; start clears, active counts.
module beta_run_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             active,
    input  logic [CNT_W-1:0] budget,
    output logic [CNT_W-1:0] count_next,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // count_next already includes the current active cycle, so the caller sees
    // the final count in the same cycle that it decides to stop.
    always_comb begin
        count_next = count;
        if (active && (count != '1))
            count_next = count + CNT_W'(1);
    end

    assign expired = active && (budget != '0) && (count_next == budget);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (start)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/beta_mau_host.sv
// Host-side initiator for the Beta CPU mau interface: command/response stream,
// memory/register access sequencing and budgeted RUN control.
// Optional feature: define BETA_HOST_WRCNT_EN to count CPU DM writes per RUN.
module beta_mau_host
    import beta_host_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [31:0] mau_address_im,
    output logic [31:0] mau_address_dm,
    output logic [31:0] mau_address_rf,
    output logic [31:0] mau_write_data_im,
    output logic [31:0] mau_write_data_dm,
    output logic [31:0] mau_write_data_rf,
    output logic        mau_wren_im,
    output logic        mau_wren_dm,
    output logic        mau_wren_rf,
    input  logic [31:0] mau_read_data_im,
    input  logic [31:0] mau_read_data_dm,
    input  logic [31:0] mau_read_data_rf,
    output logic        alive,
    input  logic        halt,
    input  logic        exported_wren_dm,
    output logic [15:0] run_dm_writes
);

    localparam int unsigned LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                  (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam logic [2:0] WAIT_INIT = 3'(LAT - 1);

    state_e      state;
    op_e         op_q;
    op_e         cmd_op_e;
    logic [31:0] data_q;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  wait_cnt;
    logic [31:0] rd_sel;
    logic        accept;
    logic        run_start;
    logic [CNT_W-1:0] run_count;
    logic        run_expired;

    assign cmd_op_e  = op_e'(cmd_op);
    assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign run_start = accept && (cmd_op_e == OP_RUN);

    assign mau_address_im    = addr_r;
    assign mau_address_dm    = addr_r;
    assign mau_address_rf    = addr_r;
    assign mau_write_data_im = wdata_r;
    assign mau_write_data_dm = wdata_r;
    assign mau_write_data_rf = wdata_r;

    always_comb begin
        rd_sel = mau_read_data_rf;
        case (op_q)
            OP_RD_IM: rd_sel = mau_read_data_im;
            OP_RD_DM: rd_sel = mau_read_data_dm;
            default:  rd_sel = mau_read_data_rf;
        endcase
    end

    beta_run_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (run_start),
        .active     (state == S_RUN),
        .budget     (CNT_W'(data_q)),
        .count_next (run_count),
        .expired    (run_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= OP_WR_IM;
            data_q      <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            mau_wren_im <= 1'b0;
            mau_wren_dm <= 1'b0;
            mau_wren_rf <= 1'b0;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_status  <= ST_OK;
            alive       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op_e;
                        data_q    <= cmd_data;
                        case (cmd_op_e)
                            OP_WR_IM, OP_WR_DM, OP_WR_RF: begin
                                addr_r      <= cmd_addr;
                                wdata_r     <= cmd_data;
                                mau_wren_im <= (cmd_op_e == OP_WR_IM);
                                mau_wren_dm <= (cmd_op_e == OP_WR_DM);
                                mau_wren_rf <= (cmd_op_e == OP_WR_RF);
                                state       <= S_ACCESS;
                            end
                            OP_RD_IM, OP_RD_DM, OP_RD_RF: begin
                                addr_r <= cmd_addr;
                                state  <= S_ACCESS;
                            end
                            OP_RUN: begin
                                alive <= 1'b1;
                                state <= S_RUN;
                            end
                            default: begin
                                rsp_valid  <= 1'b1;
                                rsp_data   <= '0;
                                rsp_status <= ST_ILLEGAL;
                                state      <= S_RSP;
                            end
                        endcase
                    end
                end
                // Strobes were raised at accept so they cover exactly this cycle.
                S_ACCESS: begin
                    mau_wren_im <= 1'b0;
                    mau_wren_dm <= 1'b0;
                    mau_wren_rf <= 1'b0;
                    wait_cnt    <= WAIT_INIT;
                    if (is_write(op_q)) begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= '0;
                        rsp_status <= ST_OK;
                        state      <= S_RSP;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= rd_sel;
                        rsp_status <= ST_OK;
                        state      <= S_RSP;
                    end
                end
                S_RUN: begin
                    if (halt || run_expired) begin
                        alive      <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= 32'(run_count);
                        rsp_status <= halt ? ST_HALTED : ST_TIMEOUT;
                        state      <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BETA_HOST_WRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run_dm_writes <= '0;
        else if (run_start)
            run_dm_writes <= '0;
        else if (alive && exported_wren_dm && (run_dm_writes != '1))
            run_dm_writes <= run_dm_writes + 16'd1;
    end
`else
    logic unused_wren_dm;
    assign unused_wren_dm = exported_wren_dm;
    assign run_dm_writes  = '0;
`endif

endmodule

// File: tb/tb_beta_mau_host.sv
// Directed bench for beta_mau_host: two instances (READ_LAT 1 and 2) with
// behavioural IM/DM/RF models and a scripted CPU halt / DM-write source.
module tb_beta_mau_host;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_valid2, cmd_ready, cmd_ready2;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_valid2, rsp_ready, rsp_ready2;
    logic [31:0] rsp_data, rsp_data2;
    logic [1:0]  rsp_status, rsp_status2;
    logic [31:0] a_im, a_dm, a_rf, w_im, w_dm, w_rf, r_im, r_dm, r_rf;
    logic        we_im, we_dm, we_rf;
    logic        alive, halt, ex_wren_dm;
    logic [15:0] run_dm_writes;
    logic [31:0] a2_im, a2_dm, a2_rf, w2_im, w2_dm, w2_rf, r2_rf, rf2_s1;
    logic        we2_im, we2_dm, we2_rf, alive2;
    logic [15:0] run_dm_writes2;

    logic [31:0] im_m [0:255];
    logic [31:0] dm_m [0:255];
    logic [31:0] rf_m [0:31];
    logic [31:0] rf2_m [0:31];

    int n_chk = 0;
    int n_fail = 0;
    int unsigned n_we_im = 0, n_we_dm = 0, n_we_rf = 0, n_alive = 0;
    logic [31:0] last_im_addr = '0, last_im_data = '0;
    int alive_seen = 0;
    int halt_at = 0;
    logic halt_force = 1'b0;
    logic dm_pulse_en = 1'b0;

    beta_mau_host #(.READ_LAT(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .mau_address_im(a_im), .mau_address_dm(a_dm), .mau_address_rf(a_rf),
        .mau_write_data_im(w_im), .mau_write_data_dm(w_dm), .mau_write_data_rf(w_rf),
        .mau_wren_im(we_im), .mau_wren_dm(we_dm), .mau_wren_rf(we_rf),
        .mau_read_data_im(r_im), .mau_read_data_dm(r_dm), .mau_read_data_rf(r_rf),
        .alive(alive), .halt(halt), .exported_wren_dm(ex_wren_dm),
        .run_dm_writes(run_dm_writes)
    );

    beta_mau_host #(.READ_LAT(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_status(rsp_status2),
        .mau_address_im(a2_im), .mau_address_dm(a2_dm), .mau_address_rf(a2_rf),
        .mau_write_data_im(w2_im), .mau_write_data_dm(w2_dm), .mau_write_data_rf(w2_rf),
        .mau_wren_im(we2_im), .mau_wren_dm(we2_dm), .mau_wren_rf(we2_rf),
        .mau_read_data_im(32'h0), .mau_read_data_dm(32'h0), .mau_read_data_rf(r2_rf),
        .alive(alive2), .halt(1'b0), .exported_wren_dm(1'b0),
        .run_dm_writes(run_dm_writes2)
    );

    // Memories: one-cycle read for u_dut, two-cycle read for u_dut2.
    always @(posedge clk) begin
        if (we_im) im_m[a_im[7:0]] <= w_im;
        if (we_dm) dm_m[a_dm[7:0]] <= w_dm;
        if (we_rf) rf_m[a_rf[4:0]] <= w_rf;
        r_im <= im_m[a_im[7:0]];
        r_dm <= dm_m[a_dm[7:0]];
        r_rf <= rf_m[a_rf[4:0]];
        if (we2_rf) rf2_m[a2_rf[4:0]] <= w2_rf;
        rf2_s1 <= rf2_m[a2_rf[4:0]];
        r2_rf  <= rf2_s1;
    end

    always @(posedge clk) begin
        if (we_im) begin
            n_we_im      <= n_we_im + 1;
            last_im_addr <= a_im;
            last_im_data <= w_im;
        end
        if (we_dm) n_we_dm <= n_we_dm + 1;
        if (we_rf) n_we_rf <= n_we_rf + 1;
        if (alive) n_alive <= n_alive + 1;
        alive_seen <= alive ? alive_seen + 1 : 0;
    end

    // During the k-th alive cycle alive_seen == k-1.
    assign halt = halt_force || ((halt_at != 0) && alive && (alive_seen >= halt_at - 1));
    assign ex_wren_dm = dm_pulse_en && alive &&
                        ((alive_seen == 2) || (alive_seen == 5) || (alive_seen == 6) || (alive_seen == 10));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit which, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_data = data;
        if (which) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
        while (!(which ? cmd_ready2 : cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    endtask

    task automatic collect(input bit which, output logic [31:0] d, output logic [1:0] s);
        int n = 0;
        @(negedge clk);
        while (!(which ? rsp_valid2 : rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("rsp_timeout", 32'd0, 32'd1);
        d = which ? rsp_data2 : rsp_data;
        s = which ? rsp_status2 : rsp_status;
        if (which) rsp_ready2 = 1'b1; else rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0; rsp_ready2 = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  s;
        int unsigned b_im, b_dm, b_rf, b_al;
        int n;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_valid2 = 1'b0; rsp_ready = 1'b0; rsp_ready2 = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_data = '0;

        #12;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alive", {31'd0, alive}, 32'd0);
        check("rst_addr", a_im, 32'd0);
        check("rst_wren", {29'd0, we_im, we_dm, we_rf}, 32'd0);
        check("rst_dm_writes", {16'd0, run_dm_writes}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // WR_IM 0x10 <- DEADBEEF
        b_im = n_we_im; b_dm = n_we_dm; b_rf = n_we_rf;
        issue(0, 3'd0, 32'h10, 32'hDEADBEEF);
        collect(0, d, s);
        check("wr_im_pulses", n_we_im - b_im, 32'd1);
        check("wr_im_addr", last_im_addr, 32'h10);
        check("wr_im_data", last_im_data, 32'hDEADBEEF);
        check("wr_im_other_wren", (n_we_dm - b_dm) + (n_we_rf - b_rf), 32'd0);
        check("wr_im_rsp_data", d, 32'd0);
        check("wr_im_rsp_status", {30'd0, s}, 32'd0);

        issue(0, 3'd3, 32'h10, 32'h0);
        collect(0, d, s);
        check("rd_im_data", d, 32'hDEADBEEF);
        check("rd_im_status", {30'd0, s}, 32'd0);

        b_dm = n_we_dm;
        issue(0, 3'd1, 32'h20, 32'h0BADF00D);
        collect(0, d, s);
        check("wr_dm_pulses", n_we_dm - b_dm, 32'd1);
        issue(0, 3'd4, 32'h20, 32'h0);
        collect(0, d, s);
        check("rd_dm_data", d, 32'h0BADF00D);

        // RF write/read on both read latencies; address changes before each read
        for (int w = 0; w < 2; w++) begin
            issue(w[0], 3'd2, 32'd3, 32'h12345678);
            collect(w[0], d, s);
            issue(w[0], 3'd2, 32'd5, 32'hCAFEF00D);
            collect(w[0], d, s);
            issue(w[0], 3'd5, 32'd3, 32'h0);
            collect(w[0], d, s);
            check(w == 0 ? "rd_rf3_lat1" : "rd_rf3_lat2", d, 32'h12345678);
            check(w == 0 ? "rd_rf3_stat_lat1" : "rd_rf3_stat_lat2", {30'd0, s}, 32'd0);
            issue(w[0], 3'd5, 32'd5, 32'h0);
            collect(w[0], d, s);
            check(w == 0 ? "rd_rf5_lat1" : "rd_rf5_lat2", d, 32'hCAFEF00D);
        end

        // Illegal op with a stalled consumer
        b_im = n_we_im; b_dm = n_we_dm; b_rf = n_we_rf;
        issue(0, 3'd7, 32'h44, 32'h55);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            check("ill_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("ill_hold_status", {30'd0, rsp_status}, 32'd3);
            check("ill_hold_data", rsp_data, 32'd0);
            check("ill_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        collect(0, d, s);
        check("ill_status", {30'd0, s}, 32'd3);
        check("ill_no_wren", (n_we_im - b_im) + (n_we_dm - b_dm) + (n_we_rf - b_rf), 32'd0);
        check("ill_addr_held", a_im, 32'd5);

        // RUN: unlimited budget, halt during alive cycle 37
        b_im = n_we_im; b_dm = n_we_dm; b_rf = n_we_rf;
        halt_at = 37; b_al = n_alive;
        issue(0, 3'd6, 32'h0, 32'd0);
        collect(0, d, s);
        check("run_halt37_count", d, 32'd37);
        check("run_halt37_status", {30'd0, s}, 32'd1);
        check("run_halt37_alive", n_alive - b_al, 32'd37);

        // RUN: budget 100, no halt, with four DM writes from the CPU
        halt_at = 0; dm_pulse_en = 1'b1; b_al = n_alive;
        issue(0, 3'd6, 32'h0, 32'd100);
        collect(0, d, s);
        dm_pulse_en = 1'b0;
        check("run_budget_count", d, 32'd100);
        check("run_budget_status", {30'd0, s}, 32'd2);
        check("run_budget_alive", n_alive - b_al, 32'd100);
`ifdef BETA_HOST_WRCNT_EN
        check("run_dm_writes", {16'd0, run_dm_writes}, 32'd4);
`else
        check("run_dm_writes", {16'd0, run_dm_writes}, 32'd0);
`endif

        // RUN: halt and budget coincide at cycle 100
        halt_at = 100;
        issue(0, 3'd6, 32'h0, 32'd100);
        collect(0, d, s);
        check("run_both_count", d, 32'd100);
        check("run_both_status", {30'd0, s}, 32'd1);

        // RUN: halt already high at entry
        halt_at = 0; halt_force = 1'b1; b_al = n_alive;
        issue(0, 3'd6, 32'h0, 32'd0);
        collect(0, d, s);
        halt_force = 1'b0;
        check("run_pre_halt_count", d, 32'd1);
        check("run_pre_halt_status", {30'd0, s}, 32'd1);
        check("run_pre_halt_alive", n_alive - b_al, 32'd1);
        check("run_no_wren", (n_we_im - b_im) + (n_we_dm - b_dm) + (n_we_rf - b_rf), 32'd0);

        // Asynchronous reset in the middle of a RUN
        issue(0, 3'd6, 32'h0, 32'd0);
        repeat (10) @(negedge clk);
        check("mid_run_alive", {31'd0, alive}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alive", {31'd0, alive}, 32'd0);
        check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("async_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 3'd3, 32'h10, 32'h0);
        collect(0, d, s);
        check("post_rst_rd_im", d, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
